// File: rtl/adc_sample_conditioner.sv
// Samples the dial and CdS readings at a fixed rate, block-averages each channel,
// and derives a hysteretic 16-step dial level and dark flag with change strobes.
`timescale 1ns/1ps
module adc_sample_conditioner #(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned DARK_ON    = 60,
    parameter int unsigned DARK_OFF   = 80,
    parameter int unsigned LEVEL_HYST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] dial_value,
    input  logic [7:0] cds_value,
    output logic [7:0] dial_avg,
    output logic [7:0] cds_avg,
    output logic       avg_valid,
    output logic [3:0] dial_level,
    output logic       level_changed,
    output logic       is_dark,
    output logic       dark_changed
);

    localparam int unsigned DIV_W     = $clog2(SAMPLE_DIV);
    localparam int unsigned ACC_W     = 8 + AVG_LOG2;
    localparam int unsigned CNT_W     = AVG_LOG2 + 1;
    localparam int unsigned N_SAMPLES = 1 << AVG_LOG2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
    localparam logic signed [9:0] HYST_S  = 10'(LEVEL_HYST);
    localparam logic [7:0] DARK_ON_V      = 8'(DARK_ON);
    localparam logic [7:0] DARK_OFF_V     = 8'(DARK_OFF);

    typedef enum logic [1:0] {
        S_ACCUM    = 2'd0,
        S_AVG      = 2'd1,
        S_CLASSIFY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   dial_sum_q, dial_sum_d;
    logic [ACC_W-1:0]   cds_sum_q, cds_sum_d;
    logic [7:0]         dial_avg_q, dial_avg_d;
    logic [7:0]         cds_avg_q, cds_avg_d;
    logic               avg_valid_q, avg_valid_d;
    logic [3:0]         level_q, level_d;
    logic               level_changed_q, level_changed_d;
    logic               is_dark_q, is_dark_d;
    logic               dark_changed_q, dark_changed_d;
    logic               tick_c;

    // Level window edges, signed 10-bit so level 0 / level 15 never wrap
    logic signed [9:0]  base_c, upper_c, lower_c, avg_s_c;
    logic               level_move_c;

    assign base_c       = $signed({2'b00, level_q, 4'b0000});
    assign upper_c      = base_c + 10'sd15 + HYST_S;
    assign lower_c      = base_c - HYST_S;
    assign avg_s_c      = $signed({2'b00, dial_avg_q});
    assign level_move_c = ((level_q != 4'd15) && (avg_s_c > upper_c)) ||
                          ((level_q != 4'd0)  && (avg_s_c < lower_c));

    always_comb begin
        state_d         = state_q;
        div_d           = div_q;
        cnt_d           = cnt_q;
        dial_sum_d      = dial_sum_q;
        cds_sum_d       = cds_sum_q;
        dial_avg_d      = dial_avg_q;
        cds_avg_d       = cds_avg_q;
        avg_valid_d     = 1'b0;
        level_d         = level_q;
        level_changed_d = 1'b0;
        is_dark_d       = is_dark_q;
        dark_changed_d  = 1'b0;
        tick_c          = 1'b0;

        if (!enable) begin
            // Disabled: discard any partial window, hold published outputs
            state_d    = S_ACCUM;
            div_d      = '0;
            cnt_d      = '0;
            dial_sum_d = '0;
            cds_sum_d  = '0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_c = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            case (state_q)
                S_ACCUM: begin
                    if (tick_c) begin
                        dial_sum_d = dial_sum_q + ACC_W'(dial_value);
                        cds_sum_d  = cds_sum_q + ACC_W'(cds_value);
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = S_AVG;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_AVG: begin
                    dial_avg_d  = 8'(dial_sum_q >> AVG_LOG2);
                    cds_avg_d   = 8'(cds_sum_q >> AVG_LOG2);
                    avg_valid_d = 1'b1;
                    dial_sum_d  = '0;
                    cds_sum_d   = '0;
                    cnt_d       = '0;
                    state_d     = S_CLASSIFY;
                end
                S_CLASSIFY: begin
                    if (level_move_c) begin
                        level_d         = dial_avg_q[7:4];
                        level_changed_d = 1'b1;
                    end
                    if (!is_dark_q && (cds_avg_q < DARK_ON_V)) begin
                        is_dark_d      = 1'b1;
                        dark_changed_d = 1'b1;
                    end else if (is_dark_q && (cds_avg_q > DARK_OFF_V)) begin
                        is_dark_d      = 1'b0;
                        dark_changed_d = 1'b1;
                    end
                    state_d = S_ACCUM;
                end
                default: state_d = S_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_ACCUM;
            div_q           <= '0;
            cnt_q           <= '0;
            dial_sum_q      <= '0;
            cds_sum_q       <= '0;
            dial_avg_q      <= '0;
            cds_avg_q       <= '0;
            avg_valid_q     <= 1'b0;
            level_q         <= '0;
            level_changed_q <= 1'b0;
            is_dark_q       <= 1'b0;
            dark_changed_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            div_q           <= div_d;
            cnt_q           <= cnt_d;
            dial_sum_q      <= dial_sum_d;
            cds_sum_q       <= cds_sum_d;
            dial_avg_q      <= dial_avg_d;
            cds_avg_q       <= cds_avg_d;
            avg_valid_q     <= avg_valid_d;
            level_q         <= level_d;
            level_changed_q <= level_changed_d;
            is_dark_q       <= is_dark_d;
            dark_changed_q  <= dark_changed_d;
        end
    end

    assign dial_avg      = dial_avg_q;
    assign cds_avg       = cds_avg_q;
    assign avg_valid     = avg_valid_q;
    assign dial_level    = level_q;
    assign level_changed = level_changed_q;
    assign is_dark       = is_dark_q;
    assign dark_changed  = dark_changed_q;

endmodule

// File: doc/adc_sample_conditioner.md
Name: adc_sample_conditioner

Overview:
- Downstream consumer of the AD7908 SPI front end.
- Takes the free-running 8-bit dial and CdS light readings and samples them at a fixed rate.
- Block-averages each channel over 2^AVG_LOG2 samples.
- Produces a stable 16-step dial level and a dark/bright flag, each with hysteresis, plus change strobes for the game/control logic.

Parameters:
- SAMPLE_DIV, 50000, clk cycles per sample tick (1 kHz at 50 MHz); must be >= 4.
- AVG_LOG2, 3, log2 of samples per averaging window (8 samples).
- DARK_ON, 60, is_dark sets when cds_avg < DARK_ON.
- DARK_OFF, 80, is_dark clears when cds_avg > DARK_OFF; must be >= DARK_ON.
- LEVEL_HYST, 4, dial hysteresis margin in LSBs beyond a level boundary.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset.
- enable  in  1  conditioning enable.
- dial_value  in  8  raw dial reading from ADC interface.
- cds_value  in  8  raw light reading from ADC interface.
- dial_avg  out  8  averaged dial value.
- cds_avg  out  8  averaged light value.
- avg_valid  out  1  one-cycle pulse when averages update.
- dial_level  out  4  hysteretic dial level 0..15.
- level_changed  out  1  one-cycle pulse when dial_level changes.
- is_dark  out  1  hysteretic darkness flag.
- dark_changed  out  1  one-cycle pulse when is_dark changes.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values: dial_avg=0, cds_avg=0, avg_valid=0, dial_level=0, level_changed=0, is_dark=0, dark_changed=0. Divider, sample counter and accumulators cleared; FSM in S_ACCUM.
- Tick divider:
  - Counter 0..SAMPLE_DIV-1 while enable=1.
  - tick asserts for one cycle when the counter = SAMPLE_DIV-1, then wraps to 0.
  - First tick comes SAMPLE_DIV cycles after enable rises.
- Accumulators: width 8+AVG_LOG2 each, so they never overflow.
- FSM S_ACCUM:
  - On tick, add dial_value and cds_value to their accumulators and increment sample count.
  - When the tick completes sample 2^AVG_LOG2, go to S_AVG.
- FSM S_AVG (1 cycle):
  - dial_avg <= dial_sum >> AVG_LOG2, cds_avg <= cds_sum >> AVG_LOG2 (truncating).
  - avg_valid=1 this cycle.
  - Clear accumulators and count; go to S_CLASSIFY.
- FSM S_CLASSIFY (1 cycle): update dial_level and is_dark from the new averages, pulse the change strobes, return to S_ACCUM.
- Latency: avg_valid is high the cycle after the final sample tick. level_changed/dark_changed and the new dial_level/is_dark appear the cycle after avg_valid.
- No tick can occur in S_AVG/S_CLASSIFY because SAMPLE_DIV >= 4, so no samples are lost.
- Dial level rule, with L = dial_level:
  - upper = 16*L+15+LEVEL_HYST, lower = 16*L-LEVEL_HYST, both computed at 10 bits signed, no wrap.
  - If L<15 and dial_avg > upper, or L>0 and dial_avg < lower: dial_level <= dial_avg[7:4] and level_changed=1.
  - Otherwise hold. A jump of several levels in one update is allowed.
- Dark rule:
  - !is_dark and cds_avg < DARK_ON -> set.
  - is_dark and cds_avg > DARK_OFF -> clear.
  - dark_changed=1 on either transition.
- enable=0:
  - Divider, count and accumulators are held at 0 and the FSM is forced to S_ACCUM.
  - Outputs hold their last values; strobes are 0.
  - Partial windows are discarded.
- Reset mid-window: reset takes effect on the next edge regardless of FSM state. No strobe is emitted on that edge.

Test Plan:
1. SAMPLE_DIV=8, AVG_LOG2=3. Reset, enable=1, dial=0x80, cds=200 -> avg_valid at cycle 65, dial_avg=0x80, cds_avg=200. Next cycle: dial_level=8, level_changed=1, is_dark=0, dark_changed=0.
2. Dial alternating 0x10/0x11 across the 8 ticks -> dial_avg=0x10 (truncation); dial_level=1.
3. From level 8: dial avg 0x93 -> level stays 8, no strobe. Avg 0x94 -> level 9, strobe. Avg 0x8C -> stays 9. Avg 0x8B -> level 8, strobe. Avg 0x05 -> level 0 in one update.
4. cds avg 50 -> is_dark=1 with dark_changed pulse. Avg 70 -> stays 1. Avg 80 -> stays 1. Avg 81 -> is_dark=0 with pulse.
5. enable dropped after 5 ticks, then restored -> no avg_valid. Next avg_valid exactly 8*8+1 cycles after re-enable, computed only from post-enable samples.
6. rst_n pulsed low for one cycle during S_ACCUM after level=8 and is_dark=1 -> all outputs 0 at that edge, no strobes. A glitch on rst_n between clock edges has no effect.
